mem_access: RTL and testbench

- MEM-stage responder for the load/store requests issued by the execute stage (mem_op, mem_addr, mem_data).
- Runs a multi-cycle asynchronous-SRAM access with a fixed wait-state count.
- Handles byte lanes for LB/SB and stalls the pipeline until the access completes.
- Forwards the register-writeback triple to WB, substituting load data for loads.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_access_if.sv | 26 ++
 rtl/mem_byte_lane.sv | 48 ++++
 rtl/mem_access.sv | 151 +++++++++++++++
 tb/tb_mem_access.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM responder: op codes, FSM state
// encoding, byte-lane indices and op classification helpers.
package mem_pkg;

  localparam logic [7:0] MEM_NOP = 8'h00;
  localparam logic [7:0] MEM_LB  = 8'h01;
  localparam logic [7:0] MEM_LW  = 8'h02;
  localparam logic [7:0] MEM_SB  = 8'h03;
  localparam logic [7:0] MEM_SW  = 8'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Unknown op codes classify as neither load nor store, i.e. behave as NOP.
  function automatic logic is_load(input logic [7:0] op);
    return (op == MEM_LB) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_word(input logic [7:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Asynchronous-SRAM bus: the controller drives strobes/address/data through
// the master modport, the memory (or its model) uses the slave modport.
interface mem_access_if #(
  parameter int ADDR_W = 20
);
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_wdata_oe;

  modport master (
    output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    output sram_addr, sram_wdata, sram_wdata_oe,
    input  sram_rdata
  );

  modport slave (
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    input  sram_addr, sram_wdata, sram_wdata_oe,
    output sram_rdata
  );
endinterface

// File: rtl/mem_byte_lane.sv
// Combinational little-endian lane logic: byte select + sign extension for
// LB, single-lane byte enable and byte replication for SB, full word otherwise.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_wdata_o,
  output logic [3:0]  be_n_o
);

  logic [7:0] byte_sel;
  logic [3:0] lane_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_hit[gi] = (lane_i == 2'(gi));
  end

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      LANE0: byte_sel = rdata_i[7:0];
      LANE1: byte_sel = rdata_i[15:8];
      LANE2: byte_sel = rdata_i[23:16];
      LANE3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  always_comb begin
    load_data_o   = rdata_i;
    store_wdata_o = store_data_i;
    be_n_o        = 4'hF;
    if (op_i == MEM_LB) begin
      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      be_n_o      = ~lane_hit;
    end else if (op_i == MEM_SB) begin
      store_wdata_o = {4{store_data_i[7:0]}};
      be_n_o        = ~lane_hit;
    end else if (is_word(op_i)) begin
      be_n_o = 4'h0;
    end
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage responder: fixed wait-state SRAM access that stalls the pipeline.
// Optional MEM_ALIGN_CHECK_EN adds addr_err and rejects misaligned LW/SW.
module mem_access
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic        stall_req,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  mem_access_if.master sram
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [31:0]       load_q;
  logic              ce_n_q, oe_n_q, we_n_q, wdata_oe_q;
  logic [3:0]        be_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] lane_load, lane_wdata;
  logic [3:0]  lane_be_n;
  logic        op_load, op_store, op_mem, misalign, start;
  logic        unused_addr_bits;

  assign op_load  = is_load(mem_op_i);
  assign op_store = is_store(mem_op_i);
  assign op_mem   = op_load || op_store;
  assign unused_addr_bits = ^mem_addr_i[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_word(mem_op_i) && (mem_addr_i[1:0] != 2'b00);
  assign addr_err = rst && (state_q == IDLE) && misalign;
`else
  assign misalign = 1'b0;
`endif

  assign start = (state_q == IDLE) && op_mem && !misalign;

  mem_byte_lane u_lane (
    .op_i          (mem_op_i),
    .lane_i        (mem_addr_i[1:0]),
    .rdata_i       (sram.sram_rdata),
    .store_data_i  (mem_data_i),
    .load_data_o   (lane_load),
    .store_wdata_o (lane_wdata),
    .be_n_o        (lane_be_n)
  );

  always_comb begin
    state_d   = state_q;
    wdata_o   = wdata_i;
    waddr_o   = waddr_i;
    we_o      = we_i;
    stall_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_mem) begin
          we_o      = 1'b0;
          stall_req = !misalign;
          if (!misalign) state_d = ACCESS;
        end
      end
      ACCESS: begin
        we_o      = 1'b0;
        stall_req = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (op_load) wdata_o = load_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      wdata_o   = '0;
      waddr_o   = '0;
      we_o      = 1'b0;
      stall_req = 1'b0;
    end
  end

  // Strobes are registered so the SRAM never sees combinational glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      load_q     <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= 4'hF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdata_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q      <= '0;
            ce_n_q     <= 1'b0;
            oe_n_q     <= !op_load;
            we_n_q     <= !op_store;
            be_n_q     <= lane_be_n;
            addr_q     <= mem_addr_i[ADDR_W+1:2];
            wdata_q    <= lane_wdata;
            wdata_oe_q <= op_store;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            if (op_load) load_q <= lane_load;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
            wdata_oe_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sram.sram_ce_n     = ce_n_q;
  assign sram.sram_oe_n     = oe_n_q;
  assign sram.sram_we_n     = we_n_q;
  assign sram.sram_be_n     = be_n_q;
  assign sram.sram_addr     = addr_q;
  assign sram.sram_wdata    = wdata_q;
  assign sram.sram_wdata_oe = wdata_oe_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (WAIT_CYCLES=2, ADDR_W=20); define
// MEM_ALIGN_CHECK_EN for both RTL and bench to exercise addr_err.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  mem_op_i = MEM_NOP;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_o;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic        stall_req;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(20)) sram_if ();

  mem_access #(.WAIT_CYCLES(2), .ADDR_W(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_op_i   (mem_op_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .wdata_i    (wdata_i),
    .waddr_i    (waddr_i),
    .we_i       (we_i),
    .wdata_o    (wdata_o),
    .waddr_o    (waddr_o),
    .we_o       (we_o),
    .stall_req  (stall_req),
`ifdef MEM_ALIGN_CHECK_EN
    .addr_err   (addr_err),
`endif
    .sram       (sram_if)
  );

  // Result of one memory transaction as observed on the bus and WB outputs.
  int          r_stall, r_oe, r_we, r_oe_data;
  logic        r_we_in_stall;
  logic [3:0]  r_be;
  logic [19:0] r_addr;
  logic [31:0] r_wdata, r_done_wdata;
  logic        r_done_we;
  logic [4:0]  r_done_waddr;

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input logic [4:0] wa, input logic we,
                           input logic [31:0] alu);
    r_stall = 0; r_oe = 0; r_we = 0; r_oe_data = 0; r_we_in_stall = 1'b0;
    r_be = 4'hF; r_addr = '0; r_wdata = '0; r_done_wdata = '0; r_done_we = 1'b0; r_done_waddr = '0;
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data;
    waddr_i = wa; we_i = we; wdata_i = alu; sram_if.sram_rdata = rdata;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_if.sram_ce_n) begin
        r_be = sram_if.sram_be_n; r_addr = sram_if.sram_addr; r_wdata = sram_if.sram_wdata;
      end
      if (!sram_if.sram_oe_n) r_oe++;
      if (!sram_if.sram_we_n) r_we++;
      if (sram_if.sram_wdata_oe) r_oe_data++;
      if (!stall_req) begin
        r_done_wdata = wdata_o; r_done_we = we_o; r_done_waddr = waddr_o;
        break;
      end
      r_stall++;
      if (we_o) r_we_in_stall = 1'b1;
    end
    $display("op=%02h addr=%08h stall=%0d oe=%0d we=%0d be=%b saddr=%05h swdata=%08h wb=%08h/%0d/%0d",
             op, addr, r_stall, r_oe, r_we, r_be, r_addr, r_wdata, r_done_wdata, r_done_waddr, r_done_we);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    wdata_i = 32'hFFFF_FFFF; waddr_i = 5'd31; we_i = 1'b1;
    #12;
    checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata_o: got %h expected 0", wdata_o); end
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rst_we_o: got %b expected 0", we_o); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_req); end
    checks++; if ({sram_if.sram_ce_n, sram_if.sram_oe_n, sram_if.sram_we_n} !== 3'b111) begin
      errors++; $display("FAIL rst_strobes: got %b expected 111", {sram_if.sram_ce_n, sram_if.sram_oe_n, sram_if.sram_we_n}); end
    checks++; if (sram_if.sram_be_n !== 4'hF) begin errors++; $display("FAIL rst_be_n: got %b expected 1111", sram_if.sram_be_n); end
    checks++; if (sram_if.sram_addr !== 20'h0 || sram_if.sram_wdata !== 32'h0 || sram_if.sram_wdata_oe !== 1'b0) begin
      errors++; $display("FAIL rst_bus: got addr %h wdata %h oe %b expected 0 0 0", sram_if.sram_addr, sram_if.sram_wdata, sram_if.sram_wdata_oe); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nop();
    mem_op_i = MEM_NOP; wdata_i = 32'h1234_5678; waddr_i = 5'd5; we_i = 1'b1;
    @(negedge clk);
    $display("op=00 nop wb=%08h/%0d/%0d stall=%b", wdata_o, waddr_o, we_o, stall_req);
    checks++; if (wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL nop_wdata: got %h expected 12345678", wdata_o); end
    checks++; if (waddr_o !== 5'd5 || we_o !== 1'b1) begin errors++; $display("FAIL nop_waddr_we: got %0d/%b expected 5/1", waddr_o, we_o); end
    checks++; if (stall_req !== 1'b0 || sram_if.sram_ce_n !== 1'b1) begin
      errors++; $display("FAIL nop_stall_ce: got %b/%b expected 0/1", stall_req, sram_if.sram_ce_n); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    do_access(MEM_LW, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 32'h1111_1111);
    checks++; if (r_stall !== 3) begin errors++; $display("FAIL lw_stall: got %0d expected 3", r_stall); end
    checks++; if (r_oe !== 2 || r_we !== 0) begin errors++; $display("FAIL lw_strobes: got oe %0d we %0d expected 2 0", r_oe, r_we); end
    checks++; if (r_addr !== 20'h4 || r_be !== 4'b0000) begin errors++; $display("FAIL lw_addr_be: got %h %b expected 4 0000", r_addr, r_be); end
    checks++; if (r_we_in_stall !== 1'b0) begin errors++; $display("FAIL lw_we_stall: got %b expected 0", r_we_in_stall); end
    checks++; if (r_done_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wdata: got %h expected deadbeef", r_done_wdata); end
    checks++; if (r_done_we !== 1'b1 || r_done_waddr !== 5'd7) begin errors++; $display("FAIL lw_we_waddr: got %b/%0d expected 1/7", r_done_we, r_done_waddr); end
    mem_op_i = MEM_NOP;
  endtask

  task automatic test_lb();
    do_access(MEM_LB, 32'h0000_0003, 32'h0, 32'h80FF_1234, 5'd3, 1'b1, 32'h0);
    checks++; if (r_done_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb3_wdata: got %h expected ffffff80", r_done_wdata); end
    checks++; if (r_be !== 4'b0111 || r_stall !== 3) begin errors++; $display("FAIL lb3_be_stall: got %b/%0d expected 0111/3", r_be, r_stall); end
    mem_op_i = MEM_NOP;
    do_access(MEM_LB, 32'h0000_0001, 32'h0, 32'h80FF_1234, 5'd4, 1'b1, 32'h0);
    checks++; if (r_done_wdata !== 32'h0000_0012) begin errors++; $display("FAIL lb1_wdata: got %h expected 00000012", r_done_wdata); end
    mem_op_i = MEM_NOP;
  endtask

  task automatic test_sb();
    do_access(MEM_SB, 32'h0000_0001, 32'h0000_00AB, 32'h0, 5'd0, 1'b0, 32'h0000_0001);
    checks++; if (r_be !== 4'b1101) begin errors++; $display("FAIL sb_be: got %b expected 1101", r_be); end
    checks++; if (r_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", r_wdata); end
    checks++; if (r_we !== 2 || r_oe !== 0) begin errors++; $display("FAIL sb_strobes: got we %0d oe %0d expected 2 0", r_we, r_oe); end
    checks++; if (r_oe_data !== 2) begin errors++; $display("FAIL sb_wdata_oe: got %0d expected 2", r_oe_data); end
    checks++; if (r_we_in_stall !== 1'b0 || r_done_we !== 1'b0) begin errors++; $display("FAIL sb_we_o: got %b/%b expected 0/0", r_we_in_stall, r_done_we); end
    checks++; if (r_done_wdata !== 32'h0000_0001) begin errors++; $display("FAIL sb_wb_alu: got %h expected 00000001", r_done_wdata); end
    mem_op_i = MEM_NOP;
  endtask

  task automatic test_back_to_back();
    do_access(MEM_LW, 32'h0000_0024, 32'h0, 32'h0BAD_F00D, 5'd9, 1'b1, 32'h0);
    checks++; if (r_stall !== 3 || r_done_wdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL b2b_lw: got %0d/%h expected 3/0badf00d", r_stall, r_done_wdata); end
    do_access(MEM_SW, 32'h0000_0028, 32'h1357_9BDF, 32'h0, 5'd0, 1'b0, 32'h0);
    checks++; if (r_stall !== 3 || r_we !== 2) begin errors++; $display("FAIL b2b_sw_timing: got %0d/%0d expected 3/2", r_stall, r_we); end
    checks++; if (r_addr !== 20'hA || r_be !== 4'b0000 || r_wdata !== 32'h1357_9BDF) begin
      errors++; $display("FAIL b2b_sw_bus: got %h %b %h expected a 0000 13579bdf", r_addr, r_be, r_wdata); end
    mem_op_i = MEM_NOP;
  endtask

  task automatic test_misaligned();
`ifdef MEM_ALIGN_CHECK_EN
    mem_op_i = MEM_LW; mem_addr_i = 32'h0000_0006; we_i = 1'b1; waddr_i = 5'd6;
    @(negedge clk);
    $display("op=02 addr=00000006 addr_err=%b stall=%b ce_n=%b", addr_err, stall_req, sram_if.sram_ce_n);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_addr_err: got %b expected 1", addr_err); end
    checks++; if (stall_req !== 1'b0 || we_o !== 1'b0) begin errors++; $display("FAIL mis_stall_we: got %b/%b expected 0/0", stall_req, we_o); end
    @(posedge clk); #1;
    checks++; if (sram_if.sram_ce_n !== 1'b1) begin errors++; $display("FAIL mis_ce_n: got %b expected 1", sram_if.sram_ce_n); end
    mem_op_i = MEM_NOP;
    @(negedge clk);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mis_addr_err_clr: got %b expected 0", addr_err); end
    @(posedge clk); #1;
`else
    do_access(MEM_LW, 32'h0000_0006, 32'h0, 32'h2468_ACE0, 5'd6, 1'b1, 32'h0);
    checks++; if (r_addr !== 20'h1 || r_be !== 4'b0000) begin errors++; $display("FAIL mis_addr_be: got %h %b expected 1 0000", r_addr, r_be); end
    checks++; if (r_done_wdata !== 32'h2468_ACE0) begin errors++; $display("FAIL mis_wdata: got %h expected 2468ace0", r_done_wdata); end
    mem_op_i = MEM_NOP;
`endif
  endtask

  task automatic test_reset_mid_access();
    mem_op_i = MEM_SW; mem_addr_i = 32'h0000_0008; mem_data_i = 32'h55AA_55AA; we_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    checks++; if (sram_if.sram_we_n !== 1'b0) begin errors++; $display("FAIL rmid_active: got we_n %b expected 0", sram_if.sram_we_n); end
    #1 rst = 1'b0;
    #1;
    $display("op=04 addr=00000008 reset mid-access ce_n=%b we_n=%b stall=%b", sram_if.sram_ce_n, sram_if.sram_we_n, stall_req);
    checks++; if ({sram_if.sram_ce_n, sram_if.sram_we_n, sram_if.sram_wdata_oe} !== 3'b110) begin
      errors++; $display("FAIL rmid_strobes: got %b expected 110", {sram_if.sram_ce_n, sram_if.sram_we_n, sram_if.sram_wdata_oe}); end
    checks++; if (stall_req !== 1'b0 || we_o !== 1'b0) begin errors++; $display("FAIL rmid_stall_we: got %b/%b expected 0/0", stall_req, we_o); end
    mem_op_i = MEM_NOP; wdata_i = 32'hCAFE_F00D; waddr_i = 5'd2; we_i = 1'b1;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (wdata_o !== 32'hCAFE_F00D || waddr_o !== 5'd2 || we_o !== 1'b1 || stall_req !== 1'b0) begin
      errors++; $display("FAIL rmid_nop: got %h/%0d/%b/%b expected cafef00d/2/1/0", wdata_o, waddr_o, we_o, stall_req); end
    @(posedge clk); #1;
    checks++; if (sram_if.sram_ce_n !== 1'b1 || stall_req !== 1'b0) begin
      errors++; $display("FAIL rmid_idle: got ce_n %b stall %b expected 1 0", sram_if.sram_ce_n, stall_req); end
  endtask

  initial begin
    sram_if.sram_rdata = '0;
    test_reset();
    test_nop();
    test_lw();
    test_lb();
    test_sb();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_access();
    test_nop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
